// File: rtl/matrix_loader.sv
// matrix_loader: column writer for the 32x16 dot-matrix display driver.
// Latency: host write accepted at edge k -> SETUP k+1, LOAD high k+2, HOLD k+3, ready again k+4.
// Backpressure: wr_ready is registered and low while a transaction runs or a scroll step is due.
//
// Ports:
//   Divided_CLK          block clock, all logic on posedge
//   RESET                synchronous active-high reset
//   wr_valid/wr_ready    host write handshake (wr_ready registered)
//   wr_id, wr_data       logical column index and its 16-bit pixel pattern
//   scroll_en            enables the scroll tick counter
//   column_id, in_column physical column address and data to the display driver
//   LOAD                 write strobe, driver captures on its rising edge
//   busy                 high whenever the FSM is not in IDLE
module matrix_loader #(
  parameter int SCROLL_DIV = 64
) (
  input  logic        Divided_CLK,
  input  logic        RESET,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_id,
  input  logic [15:0] wr_data,
  input  logic        scroll_en,
  output logic [4:0]  column_id,
  output logic [15:0] in_column,
  output logic        LOAD,
  output logic        busy
);

  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_nxt;
  logic          sweep_mode, sweep_mode_nxt;
  logic [4:0]    p_idx, p_idx_nxt;
  logic [4:0]    offset, offset_nxt;
  logic          pending, pending_nxt;
  logic [CW-1:0] tick_cnt, tick_cnt_nxt;
  logic [4:0]    col_q, col_nxt;
  logic [15:0]   dat_q, dat_nxt;
  logic          wr_ready_q, wr_ready_nxt;
  logic [15:0]   shadow [32];

  logic          accept;
  logic          tick;
  logic          host_start;
  logic [4:0]    p_inc;
  logic [4:0]    rd_idx;

  assign accept = wr_valid & wr_ready_q;
  assign tick   = scroll_en & (tick_cnt == CNT_MAX);
  assign p_inc  = p_idx + 5'd1;

  // wr_ready is only ever high in IDLE with nothing pending, so an accept
  // always launches a host transaction; the pending check is belt and braces.
  assign host_start = (state == IDLE) & ~pending & accept;

  always_comb begin
    state_nxt      = state;
    sweep_mode_nxt = sweep_mode;
    p_idx_nxt      = p_idx;
    offset_nxt     = offset;
    pending_nxt    = pending;
    col_nxt        = col_q;
    dat_nxt        = dat_q;
    rd_idx         = 5'd0;
    tick_cnt_nxt   = '0;

    if (scroll_en) begin
      tick_cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (pending) begin
          // Sweep start: advance the scroll offset first, column 0 already
          // shows the rotated image.
          state_nxt      = SETUP;
          sweep_mode_nxt = 1'b1;
          offset_nxt     = offset + 5'd1;
          p_idx_nxt      = 5'd0;
          pending_nxt    = 1'b0;
          rd_idx         = offset + 5'd1;
          col_nxt        = 5'd0;
          dat_nxt        = shadow[rd_idx];
        end else if (host_start) begin
          // Logical column l sits at physical (l - offset) mod 32.
          state_nxt      = SETUP;
          sweep_mode_nxt = 1'b0;
          col_nxt        = wr_id - offset;
          dat_nxt        = wr_data;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: state_nxt = HOLD;
      HOLD: begin
        if (sweep_mode && (p_idx != 5'd31)) begin
          // Next sweep column follows immediately, no IDLE gap.
          state_nxt = SETUP;
          p_idx_nxt = p_inc;
          rd_idx    = p_inc + offset;
          col_nxt   = p_inc;
          dat_nxt   = shadow[rd_idx];
        end else begin
          state_nxt      = IDLE;
          sweep_mode_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A tick on the sweep-start edge belongs to the next step, so set wins
    // over clear; repeated ticks simply coalesce.
    if (tick) begin
      pending_nxt = 1'b1;
    end

    wr_ready_nxt = (state_nxt == IDLE) & ~pending_nxt;
  end

  always_ff @(posedge Divided_CLK) begin
    if (RESET) begin
      state      <= IDLE;
      sweep_mode <= 1'b0;
      p_idx      <= 5'd0;
      offset     <= 5'd0;
      pending    <= 1'b0;
      tick_cnt   <= '0;
      col_q      <= 5'd0;
      dat_q      <= 16'd0;
      wr_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      sweep_mode <= sweep_mode_nxt;
      p_idx      <= p_idx_nxt;
      offset     <= offset_nxt;
      pending    <= pending_nxt;
      tick_cnt   <= tick_cnt_nxt;
      col_q      <= col_nxt;
      dat_q      <= dat_nxt;
      wr_ready_q <= wr_ready_nxt;
    end
  end

  // Shadow image is indexed by logical column; only host writes touch it,
  // and those cannot happen during a sweep.
  always_ff @(posedge Divided_CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        shadow[i] <= 16'd0;
      end
    end else if (host_start) begin
      shadow[wr_id] <= wr_data;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign column_id = col_q;
  assign in_column = dat_q;
  assign LOAD      = (state == STROBE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed bench for matrix_loader with SCROLL_DIV=4.
// Host writes come from a vector table with hand-computed physical columns;
// sweeps are checked column by column against a small shadow/offset model.
module tb_matrix_loader;

  localparam int DIV = 4;

  logic        Divided_CLK = 1'b0;
  logic        RESET;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_id;
  logic [15:0] wr_data;
  logic        scroll_en;
  logic [4:0]  column_id;
  logic [15:0] in_column;
  logic        LOAD;
  logic        busy;

  matrix_loader #(.SCROLL_DIV(DIV)) dut (
    .Divided_CLK (Divided_CLK),
    .RESET       (RESET),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_id       (wr_id),
    .wr_data     (wr_data),
    .scroll_en   (scroll_en),
    .column_id   (column_id),
    .in_column   (in_column),
    .LOAD        (LOAD),
    .busy        (busy)
  );

  always #5 Divided_CLK = ~Divided_CLK;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_shadow [32];
  logic [4:0]  m_off;

  typedef struct {
    logic [4:0]  id;
    logic [15:0] data;
    logic [4:0]  col;   // expected physical column at the time of the write
  } wvec_t;

  wvec_t tv [7];

  task automatic step();
    @(posedge Divided_CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scroll tick: SCROLL_DIV cycles of scroll_en from a zero counter.
  task automatic tick();
    scroll_en = 1'b1;
    repeat (DIV) step();
    scroll_en = 1'b0;
  endtask

  task automatic do_write(input int idx);
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_id    = tv[idx].id;
    wr_data  = tv[idx].data;
    step();
    wr_valid = 1'b0;
    m_shadow[tv[idx].id] = tv[idx].data;
    check("wr_setup",  {9'd0, busy, LOAD, column_id, in_column},
                       {9'd0, 1'b1, 1'b0, tv[idx].col, tv[idx].data});
    step();
    check("wr_strobe", {9'd0, busy, LOAD, column_id, in_column},
                       {9'd0, 1'b1, 1'b1, tv[idx].col, tv[idx].data});
    step();
    check("wr_hold",   {8'd0, wr_ready, busy, LOAD, column_id, in_column},
                       {8'd0, 1'b0, 1'b1, 1'b0, tv[idx].col, tv[idx].data});
    step();
    check("wr_done",   {29'd0, wr_ready, busy, LOAD}, {29'd0, 3'b100});
  endtask

  task automatic run_sweep(input string tag);
    int n;
    int bad;
    logic [4:0]  ix;
    logic [15:0] exp;
    m_off = m_off + 5'd1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_start"}, {31'd0, busy}, 32'd1);
    bad = 0;
    for (int p = 0; p < 32; p++) begin
      ix  = 5'(p) + m_off;
      exp = m_shadow[ix];
      for (int ph = 0; ph < 3; ph++) begin
        if (ph == 1) begin
          check({tag, "_col"}, {10'd0, LOAD, column_id, in_column},
                               {10'd0, 1'b1, 5'(p), exp});
        end
        if ({LOAD, column_id, in_column, busy, wr_ready} !==
            {(ph == 1), 5'(p), exp, 1'b1, 1'b0}) begin
          bad++;
        end
        step();
      end
    end
    check({tag, "_shape"}, bad, 0);
    check({tag, "_end"}, {30'd0, busy, LOAD}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;

    tv[0] = '{id: 5'd5,  data: 16'hA5A5, col: 5'd5};   // offset 0
    tv[1] = '{id: 5'd31, data: 16'hBEEF, col: 5'd31};  // offset 0
    tv[2] = '{id: 5'd0,  data: 16'h0001, col: 5'd0};   // offset 0
    tv[3] = '{id: 5'd0,  data: 16'hFFFF, col: 5'd31};  // offset 1
    tv[4] = '{id: 5'd3,  data: 16'h3333, col: 5'd1};   // offset 2
    tv[5] = '{id: 5'd7,  data: 16'h0707, col: 5'd7};   // offset wrapped to 0
    tv[6] = '{id: 5'd4,  data: 16'h4444, col: 5'd4};   // after reset, offset 0

    for (int i = 0; i < 32; i++) m_shadow[i] = 16'd0;
    m_off     = 5'd0;
    RESET     = 1'b1;
    wr_valid  = 1'b1;
    wr_id     = 5'd9;
    wr_data   = 16'h1234;
    scroll_en = 1'b0;

    // Reset held 3 cycles with wr_valid high: nothing accepted, outputs 0.
    for (int c = 0; c < 3; c++) begin
      step();
      check("reset_outs", {8'd0, wr_ready, busy, LOAD, column_id, in_column}, 32'd0);
    end
    RESET    = 1'b0;
    wr_valid = 1'b0;
    step();
    check("ready_after_reset", {31'd0, wr_ready}, 32'd1);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (LOAD !== 1'b0 || busy !== 1'b0) pulses++;
      step();
    end
    check("idle_after_reset", pulses, 0);

    // Single writes at offset 0.
    for (int i = 0; i < 3; i++) do_write(i);

    // First scroll step: offset 0 -> 1.
    tick();
    run_sweep("sweep1");

    // Mapped write at offset 1.
    do_write(3);

    // Tick due while the host is requesting: sweep goes first.
    tick();
    wr_valid = 1'b1;
    wr_id    = tv[4].id;
    wr_data  = tv[4].data;
    check("prio_ready_low", {30'd0, wr_ready, busy}, 32'd0);
    run_sweep("prio");
    do_write(4);

    // Remaining 30 steps bring the offset back to 0.
    for (int s = 0; s < 30; s++) begin
      tick();
      run_sweep("wrap");
    end
    do_write(5);

    // Reset in the middle of a sweep, during the STROBE of column 10.
    tick();
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("mid_start", {31'd0, busy}, 32'd1);
    repeat (31) step();
    check("mid_strobe", {26'd0, LOAD, column_id}, {26'd0, 1'b1, 5'd10});
    RESET = 1'b1;
    step();
    check("mid_reset", {8'd0, wr_ready, busy, LOAD, column_id, in_column}, 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) m_shadow[i] = 16'd0;
    m_off  = 5'd0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (LOAD === 1'b1 || busy === 1'b1) pulses++;
    end
    check("mid_no_pulses", pulses, 0);

    // Offset is back to 0 and the shadow is cleared.
    do_write(6);
    tick();
    run_sweep("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
